// File: rtl/sram_like_arbiter_2x1.sv
// sram_like_arbiter_2x1: merges inst-side and data-side sram-like masters onto one sram-like port
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   inst_*                       inst-side sram-like slave port (req/wr/size/addr/wdata in, rdata/addr_ok/data_ok out)
//   data_*                       data-side sram-like slave port (same shape as inst_*)
//   mem_*                        merged sram-like master port toward the single memory interface
//   err_unexpected               sticky flag: mem_data_ok arrived with nothing outstanding
module sram_like_arbiter_2x1 #(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic [31:0] inst_rdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   output logic        err_unexpected
);
   localparam int AW = $clog2(DEPTH);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
   localparam logic [SW-1:0] SLIM     = SW'(STARVE_LIMIT);
   // owner_q holds one bit per outstanding transaction: 0 = inst, 1 = data
   logic [DEPTH-1:0] owner_q, owner_d;
   logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [AW:0]      count_q, count_d;
   logic             lock_q, lock_d, lock_sel_q, lock_sel_d;
   logic [SW-1:0]    starve_q, starve_d;
   logic             err_q, err_d;
   logic             full, sel_data, sel_req, push, pop, head_data;
   always_comb begin
      full      = count_q == CNT_FULL;
      // an unfinished handshake pins the selection so the request never changes under it
      sel_data  = lock_q ? lock_sel_q : data_req && (!inst_req || starve_q < SLIM);
      sel_req   = sel_data ? data_req : inst_req;
      push      = sel_req && !full && mem_addr_ok;
      pop       = mem_data_ok && count_q != '0;
      head_data = owner_q[head_q];
      owner_d   = owner_q;
      if (push) owner_d[tail_q] = sel_data;
      head_d    = pop ? head_q + 1'b1 : head_q;
      tail_d    = push ? tail_q + 1'b1 : tail_q;
      count_d   = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      lock_d    = sel_req && !full && !mem_addr_ok;
      lock_sel_d = lock_d ? sel_data : lock_sel_q;
      // starve counter tracks consecutive data grants made while inst is waiting
      starve_d  = (!inst_req || (push && !sel_data)) ? '0 :
                  (push && sel_data && starve_q != SLIM) ? starve_q + 1'b1 : starve_q;
      err_d     = err_q || (mem_data_ok && count_q == '0);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q    <= '0;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         lock_q     <= 1'b0;
         lock_sel_q <= 1'b0;
         starve_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         owner_q    <= owner_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         lock_q     <= lock_d;
         lock_sel_q <= lock_sel_d;
         starve_q   <= starve_d;
         err_q      <= err_d;
      end
   end
   assign mem_req        = sel_req && !full;
   assign mem_wr         = sel_data ? data_wr : inst_wr;
   assign mem_size       = sel_data ? data_size : inst_size;
   assign mem_addr       = sel_data ? data_addr : inst_addr;
   assign mem_wdata      = sel_data ? data_wdata : inst_wdata;
   assign inst_addr_ok   = push && !sel_data;
   assign data_addr_ok   = push && sel_data;
   assign inst_data_ok   = pop && !head_data;
   assign data_data_ok   = pop && head_data;
   assign inst_rdata     = mem_rdata;
   assign data_rdata     = mem_rdata;
   assign err_unexpected = err_q;
endmodule

// File: tb/tb_sram_like_arbiter_2x1.sv
// tb_sram_like_arbiter_2x1: directed and randomized checks of the 2x1 sram-like arbiter against a queue model
module tb_sram_like_arbiter_2x1;
   localparam int DEPTH = 4;
   localparam int SLIM  = 4;
   logic        clk = 1'b0, rst = 1'b1;
   logic        inst_req = 1'b0, inst_wr = 1'b0;
   logic [1:0]  inst_size = '0;
   logic [31:0] inst_addr = '0, inst_wdata = '0;
   logic [31:0] inst_rdata;
   logic        inst_addr_ok, inst_data_ok;
   logic        data_req = 1'b0, data_wr = 1'b0;
   logic [1:0]  data_size = '0;
   logic [31:0] data_addr = '0, data_wdata = '0;
   logic [31:0] data_rdata;
   logic        data_addr_ok, data_data_ok;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
   logic        err_unexpected;
   int n_checks = 0, n_fail = 0;
   // model: queue of owners of outstanding transactions, side pending an unfinished handshake
   bit oq[$];
   int starve = 0, pend = -1;
   bit m_err = 0;
   bit e_sel, e_req, e_push, e_pop, e_iaok, e_daok;
   logic [4:0] g;
   bit ip = 0, dp = 0;
   int acc = 4, ret = 4;
   always #5 clk = ~clk;
   sram_like_arbiter_2x1 #(.DEPTH(DEPTH), .STARVE_LIMIT(SLIM)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
      .err_unexpected(err_unexpected)
   );
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic settle();
      #1;
      e_sel  = (pend >= 0) ? (pend == 1) : (data_req && (!inst_req || starve < SLIM));
      e_req  = (e_sel ? data_req : inst_req) && oq.size() < DEPTH;
      e_push = e_req && mem_addr_ok;
      e_pop  = mem_data_ok && oq.size() > 0;
      e_iaok = e_push && !e_sel;
      e_daok = e_push && e_sel;
      if (!rst) begin
         check("mem_req", mem_req, e_req);
         if (e_req) begin
            check("mem_addr", mem_addr, e_sel ? data_addr : inst_addr);
            check("mem_wr", mem_wr, e_sel ? data_wr : inst_wr);
            check("mem_size", mem_size, e_sel ? data_size : inst_size);
            check("mem_wdata", mem_wdata, e_sel ? data_wdata : inst_wdata);
         end
         check("inst_addr_ok", inst_addr_ok, e_iaok);
         check("data_addr_ok", data_addr_ok, e_daok);
         check("inst_data_ok", inst_data_ok, e_pop && !oq[0]);
         check("data_data_ok", data_data_ok, e_pop && oq[0]);
         check("inst_rdata", inst_rdata, mem_rdata);
         check("data_rdata", data_rdata, mem_rdata);
         check("err_unexpected", err_unexpected, m_err);
      end
   endtask
   task automatic advance();
      if (rst) begin
         oq.delete();
         starve = 0;
         pend = -1;
         m_err = 0;
      end else begin
         if (mem_data_ok && !e_pop) m_err = 1;
         if (e_pop) void'(oq.pop_front());
         if (e_push) oq.push_back(e_sel);
         if (!inst_req || (e_push && !e_sel)) starve = 0;
         else if (e_push && e_sel && starve < SLIM) starve++;
         pend = (e_req && !mem_addr_ok) ? int'(e_sel) : -1;
      end
      @(negedge clk);
   endtask
   task automatic idle();
      inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
   endtask
   task automatic do_reset();
      idle();
      rst = 1;
      settle(); advance();
      settle(); advance();
      rst = 0;
   endtask
   initial begin
      // reset state
      do_reset();
      settle();
      check("rst_mem_req", mem_req, 0);
      check("rst_iaok", inst_addr_ok, 0);
      check("rst_daok", data_addr_ok, 0);
      check("rst_idok", inst_data_ok, 0);
      check("rst_ddok", data_data_ok, 0);
      check("rst_err", err_unexpected, 0);
      advance();
      // single inst read with immediate accept and next-cycle data
      inst_req = 1; inst_wr = 0; inst_addr = 32'hBFC00000; mem_addr_ok = 1;
      settle();
      check("t1_iaok", inst_addr_ok, 1);
      check("t1_addr", mem_addr, 32'hBFC00000);
      advance();
      inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h3C1D0001;
      settle();
      check("t1_idok", inst_data_ok, 1);
      check("t1_rdata", inst_rdata, 32'h3C1D0001);
      check("t1_ddok", data_data_ok, 0);
      advance();
      // both requesting, slave always ready: data wins until the starve limit
      do_reset();
      inst_addr = 32'h100; data_addr = 32'h200; g = '0;
      for (int k = 0; k < 6; k++) begin
         inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = (k > 0); mem_rdata = k;
         settle();
         if (k < 5) g = {g[3:0], data_addr_ok};
         if (k == 5) check("starve_pop_owner", inst_data_ok, 1);
         advance();
      end
      check("starve_grants", g, 5'b11110);
      // stalled inst handshake must not switch when data arrives
      do_reset();
      inst_addr = 32'h1000; data_addr = 32'h2000;
      for (int k = 0; k < 3; k++) begin
         inst_req = 1; data_req = (k >= 1); mem_addr_ok = 0;
         settle();
         check("lock_addr", mem_addr, 32'h1000);
         check("lock_iaok", inst_addr_ok, 0);
         advance();
      end
      mem_addr_ok = 1;
      settle();
      check("lock_accept_i", inst_addr_ok, 1);
      check("lock_accept_d", data_addr_ok, 0);
      advance();
      inst_req = 0;
      settle();
      check("lock_after_d", data_addr_ok, 1);
      check("lock_after_addr", mem_addr, 32'h2000);
      advance();
      // fill to DEPTH, pop while full still blocks, acceptance next cycle
      do_reset();
      for (int k = 0; k < 4; k++) begin
         inst_req = 1; inst_addr = k * 4; mem_addr_ok = 1;
         settle();
         check("full_fill", inst_addr_ok, 1);
         advance();
      end
      data_req = 1;
      settle();
      check("full_req", mem_req, 0);
      check("full_iaok", inst_addr_ok, 0);
      check("full_daok", data_addr_ok, 0);
      advance();
      mem_data_ok = 1;
      settle();
      check("full_pop_req", mem_req, 0);
      check("full_pop_idok", inst_data_ok, 1);
      advance();
      mem_data_ok = 0;
      settle();
      check("full_resume", data_addr_ok, 1);
      advance();
      // I,D,I ordering of returns, then push+pop across pointer wrap
      do_reset();
      inst_req = 1; inst_addr = 32'h10; mem_addr_ok = 1;
      settle(); check("ord_i0", inst_addr_ok, 1); advance();
      inst_req = 0; data_req = 1; data_addr = 32'h20;
      settle(); check("ord_d1", data_addr_ok, 1); advance();
      data_req = 0; inst_req = 1;
      settle(); check("ord_i2", inst_addr_ok, 1); advance();
      idle();
      mem_data_ok = 1; mem_rdata = 32'h11;
      settle(); check("ord_r0", inst_data_ok, 1); check("ord_r0d", inst_rdata, 32'h11); advance();
      mem_rdata = 32'h22;
      settle(); check("ord_r1", data_data_ok, 1); check("ord_r1d", data_rdata, 32'h22); advance();
      mem_rdata = 32'h33;
      settle(); check("ord_r2", inst_data_ok, 1); check("ord_r2d", inst_rdata, 32'h33); advance();
      for (int k = 0; k < 8; k++) begin
         inst_req = 1; inst_addr = 32'h40 + k; mem_addr_ok = 1; mem_data_ok = (k > 0); mem_rdata = k;
         settle();
         check("wrap_req", mem_req, 1);
         check("wrap_iaok", inst_addr_ok, 1);
         if (k > 0) check("wrap_idok", inst_data_ok, 1);
         advance();
      end
      // data_ok with nothing outstanding
      do_reset();
      mem_data_ok = 1;
      settle();
      check("err_idok", inst_data_ok, 0);
      check("err_ddok", data_data_ok, 0);
      advance();
      mem_data_ok = 0;
      for (int k = 0; k < 3; k++) begin
         settle();
         check("err_sticky", err_unexpected, 1);
         advance();
      end
      do_reset();
      settle();
      check("err_cleared", err_unexpected, 0);
      advance();
      // randomized traffic with well-behaved requesters and an in-order slave
      for (int c = 0; c < 4000; c++) begin
         if (c % 800 == 0) begin
            acc = $urandom_range(1, 4);
            ret = $urandom_range(1, 4);
         end
         rst = ($urandom_range(0, 599) == 0);
         if (!ip && $urandom_range(0, 2) == 0) begin
            ip = 1; inst_wr = 1'($urandom); inst_size = 2'($urandom);
            inst_addr = $urandom; inst_wdata = $urandom;
         end
         if (!dp && $urandom_range(0, 2) == 0) begin
            dp = 1; data_wr = 1'($urandom); data_size = 2'($urandom);
            data_addr = $urandom; data_wdata = $urandom;
         end
         inst_req = ip; data_req = dp;
         mem_addr_ok = $urandom_range(0, 4) < acc;
         mem_data_ok = (oq.size() > 0) ? ($urandom_range(0, 4) < ret) : ($urandom_range(0, 199) == 0);
         mem_rdata = $urandom;
         settle();
         if (e_iaok || rst) ip = 0;
         if (e_daok || rst) dp = 0;
         advance();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
